switch_pio_debounced: RTL and testbench
=======================================

Name: switch_pio_debounced

Overview:
Parametrised Avalon-MM slave input PIO for board switches and buttons. It synchronises a WIDTH-bit asynchronous input bus and debounces each bit independently. Each bit has edge capture with a per-bit interrupt mask, and the block drives an active-high irq to the HPS/Nios interconnect. It replaces the single-bit, data-only switch PIO in the Qsys system.

Parameters:
WIDTH, 4, number of input bits (1..32).
SYNC_STAGES, 2, synchroniser flops per bit (2..4).
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a new level must persist before it is accepted (1..2^20).
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous assert, active-low
address  in  2  Avalon register address
chipselect  in  1  Avalon chip select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
irq  out  1  interrupt request, active-high, level
in_port  in  WIDTH  raw switch inputs, asynchronous to clk

Behaviour:
- Clocking: one clock, clk. Reset reset_n is asynchronous, active-low. All flops clear when reset_n is low, regardless of clk.
- Reset values: sync chain 0, stable 0, debounce counters 0, irqmask 0, edgecapture 0, readdata 0, irq 0.
- Synchroniser: SYNC_STAGES flops per bit; sync_out is the last stage.
- Debounce, per bit i:
  - If sync_out[i] == stable[i], counter[i] <= 0.
  - Otherwise, if counter[i] == DEBOUNCE_CYCLES-1, then stable[i] <= sync_out[i] and counter[i] <= 0.
  - Otherwise counter[i] increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1. It never wraps.
- Latency: in_port step held steady at edge 0 -> stable updates at edge SYNC_STAGES+DEBOUNCE_CYCLES -> visible on readdata one edge later.
- Edge event: asserted on the same edge stable[i] updates, filtered by EDGE_TYPE.
  - Rising: 0->1 only. Falling: 1->0 only. Any: both.
  - Because stable resets to 0, a switch held high through reset yields one rising event after debounce. This is intended; software clears it at init.
- Register map (WIDTH bits used, upper bits read 0, writes to them ignored):
  - addr 0 DATA: read returns stable. Writes ignored.
  - addr 1: reserved. Reads 0, writes ignored.
  - addr 2 IRQMASK: read/write.
  - addr 3 EDGECAP: read returns edgecapture. A write clears every bit whose writedata bit is 1 (write-1-to-clear).
- Write qualifier: chipselect && !write_n, sampled on clk.
- Simultaneous edge event and write-1-to-clear on the same bit in the same cycle: the bit ends set (event wins).
- Read path:
  - readdata <= mux(address) every cycle, as in the existing PIO. Read latency is 1, with no read strobe and no wait states.
  - Reads have no side effects.
- irq: registered, irq <= |(edgecapture & irqmask), where both terms are the current register values. irq therefore follows edgecapture by one cycle and deasserts one cycle after the clearing write.
- Reset mid-debounce: the count is abandoned, stable returns to 0, and no edge is reported for the interrupted transition.

Decomposition:
- Package switch_pio_pkg holds:
  - register address constants: ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings;
  - a clog2 helper for counter width.
- One sub-module, switch_debounce_bit: synchroniser, counter and stable flop for a single bit, with outputs stable and update pulse. Instantiate it WIDTH times in a generate loop. Register file, edge logic and irq stay in the top module.

Test Plan:
1. Reset sanity, run with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 -> after reset_n rises, reads of addr 0, 2 and 3 return 0x0, and irq=0.
2. in_port 0000->0101 held steady -> DATA reads 0x5 exactly 2+4+1 edges after the step (not before). EDGECAP reads 0x5 with EDGE_TYPE=0.
3. Glitch: bit0 high for 3 cycles then low -> DATA stays 0x0 and EDGECAP stays 0x0. Repeat with 4 cycles high -> DATA bit0=1.
4. Interrupt: IRQMASK=0x1, bit0 rises -> irq=1 one cycle after EDGECAP bit0 sets. Write 0x1 to addr 3 -> EDGECAP=0 and irq=0 one cycle later. With IRQMASK=0x0, the same edge leaves irq=0.
5. Collision: write 0x2 to EDGECAP in the same cycle bit1's rising event fires -> EDGECAP bit1 remains 1.
6. EDGE_TYPE=1 and =2 builds: bit2 0->1->0 -> falling build captures only the 1->0 transition; any build captures both (clear between them to observe each). Async reset asserted mid-count -> all registers 0 immediately, no edge reported.

Source files
------------

// File: rtl/switch_pio_pkg.sv
// Shared constants for the debounced switch PIO: register map, edge-select
// encodings and the counter-width helper.
package switch_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RESV    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Ceiling log2, usable in constant expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One input bit: metastability synchroniser followed by a persistence counter
// that accepts a new level only after it has held for DEBOUNCE_CYCLES cycles.
module switch_debounce_bit
  import switch_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic stable,
  output logic update
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt;

  // synchroniser stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_p <= '0;
    else          sync_p <= {sync_p[SYNC_STAGES-2:0], in_raw};
  end

  assign sync_out = sync_p[SYNC_STAGES-1];

  // High in the cycle whose closing edge commits sync_out into stable.
  assign update = (sync_out != stable) && (cnt == CNT_MAX);

  // debounce stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_out == stable) begin
      cnt <= '0;
    end else if (update) begin
      stable <= sync_out;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/switch_pio_debounced.sv
// Avalon-MM input PIO: per-bit debounced switch levels, edge capture with
// write-1-to-clear, per-bit interrupt mask and a registered level irq.
module switch_pio_debounced
  import switch_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .in_raw (in_port[i]),
      .stable (stable[i]),
      .update (update[i])
    );
  end

  // stable still holds the old level while update is high
  always_comb begin
    edge_evt = update;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_evt = update & ~stable;
      EDGE_FALLING: edge_evt = update & stable;
      default:      edge_evt = update;
    endcase
  end

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    clr_mask = '0;
    if (wr_en && (address == ADDR_EDGECAP)) clr_mask = writedata[WIDTH-1:0];
  end

  // register file stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && (address == ADDR_IRQMASK)) irqmask <= writedata[WIDTH-1:0];
      // A new event outranks a simultaneous clear of the same bit.
      edgecapture <= (edgecapture & ~clr_mask) | edge_evt;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
      default:      rd_mux = '0;
    endcase
  end

  // output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_switch_pio_debounced.sv
// Directed bench: three builds (rising, falling, any edge) sharing one bus and
// input, checked against hand-computed register values.
module tb_switch_pio_debounced;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int errors = 0;

  switch_pio_debounced #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .irq(irq0), .in_port(in_port));
  switch_pio_debounced #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .irq(irq1), .in_port(in_port));
  switch_pio_debounced #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .irq(irq2), .in_port(in_port));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in_val;
    logic [1:0]  addr;
    logic [31:0] e_rise;
    logic [31:0] e_fall;
    logic [31:0] e_any;
    bit          clr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check3(input string name, input logic [31:0] er, input logic [31:0] ef,
                        input logic [31:0] ea);
    check({name, "_rise"}, rd0, er);
    check({name, "_fall"}, rd1, ef);
    check({name, "_any"},  rd2, ea);
  endtask

  initial begin
    // in, addr, rise, fall, any, clear-after
    vecs[0]  = '{4'h0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[1]  = '{4'h0, 2'd1, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[2]  = '{4'h0, 2'd2, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[3]  = '{4'h0, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{4'h0, 2'd3, 32'h0, 32'h5, 32'h5, 1'b0};
    vecs[5]  = '{4'h0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{4'hA, 2'd0, 32'hA, 32'hA, 32'hA, 1'b0};
    vecs[7]  = '{4'hA, 2'd3, 32'hA, 32'h0, 32'hA, 1'b1};
    vecs[8]  = '{4'h6, 2'd3, 32'h4, 32'h8, 32'hC, 1'b0};
    vecs[9]  = '{4'h6, 2'd0, 32'h6, 32'h6, 32'h6, 1'b1};
    vecs[10] = '{4'h0, 2'd3, 32'h0, 32'h6, 32'h6, 1'b1};
    vecs[11] = '{4'h0, 2'd1, 32'h0, 32'h0, 32'h0, 1'b0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'h0;
    tick(3);
    check("reset_hold_rd", rd0, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Reset sanity: first four table rows
    for (int i = 0; i < 4; i++) begin
      rd(vecs[i].addr);
      check3($sformatf("reset_addr%0d", vecs[i].addr), vecs[i].e_rise, vecs[i].e_fall, vecs[i].e_any);
    end
    check("reset_irq", {31'h0, irq0 | irq1 | irq2}, 32'h0);

    // Step latency: DATA changes exactly 2+4+1 edges after the step
    address = 2'd0;
    in_port = 4'h5;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 6) check("latency_early", rd0, 32'h0);
      if (k == 7) check("latency_data", rd0, 32'h5);
    end
    rd(2'd3);
    check3("step_edgecap", 32'h5, 32'h0, 32'h5);
    wr(2'd3, 32'hF);

    // Table: level patterns and accumulated edge captures
    for (int i = 4; i < 12; i++) begin
      in_port = vecs[i].in_val;
      tick(10);
      rd(vecs[i].addr);
      check3($sformatf("vec%0d", i), vecs[i].e_rise, vecs[i].e_fall, vecs[i].e_any);
      if (vecs[i].clr) wr(2'd3, 32'hF);
    end

    // Mask register: upper bits dropped; writes to DATA/reserved ignored
    wr(2'd2, 32'hFFFF_FFF5);
    wr(2'd0, 32'hF);
    wr(2'd1, 32'hF);
    rd(2'd2);
    check("irqmask_rw", rd0, 32'h5);
    rd(2'd0);
    check("data_ro", rd0, 32'h0);
    wr(2'd2, 32'h0);

    // Glitch of 3 cycles is rejected
    address = 2'd0;
    in_port = 4'h1;
    tick(3);
    in_port = 4'h0;
    tick(10);
    check("glitch3_data", rd0, 32'h0);
    rd(2'd3);
    check3("glitch3_edgecap", 32'h0, 32'h0, 32'h0);

    // 4 cycles is accepted
    address = 2'd0;
    in_port = 4'h1;
    tick(4);
    in_port = 4'h0;
    tick(3);
    check("pulse4_data", rd0, 32'h1);
    tick(10);
    rd(2'd3);
    check3("pulse4_edgecap", 32'h1, 32'h1, 32'h1);
    wr(2'd3, 32'hF);

    // Interrupt assert and clear
    wr(2'd2, 32'h1);
    address = 2'd3;
    in_port = 4'h1;
    tick(6);
    check("irq_before", {31'h0, irq0}, 32'h0);
    tick(1);
    check("irq_edgecap", rd0, 32'h1);
    check("irq_set", {31'h0, irq0}, 32'h1);
    check("irq_fall_build", {31'h0, irq1}, 32'h0);
    check("irq_any_build", {31'h0, irq2}, 32'h1);
    wr(2'd3, 32'h1);
    check("irq_hold_on_clear", {31'h0, irq0}, 32'h1);
    tick(1);
    check("irq_cleared", {31'h0, irq0}, 32'h0);
    check("edgecap_cleared", rd0, 32'h0);

    // Masked edge leaves irq low
    wr(2'd2, 32'h0);
    in_port = 4'h0;
    tick(10);
    in_port = 4'h1;
    tick(10);
    check("irq_masked", {31'h0, irq0 | irq1 | irq2}, 32'h0);
    rd(2'd3);
    check("masked_edgecap", rd0, 32'h1);
    wr(2'd3, 32'hF);

    // Clear write lands on the edge where bit1's event fires
    in_port = 4'h3;
    tick(5);
    wr(2'd3, 32'h2);
    rd(2'd3);
    check3("collision", 32'h2, 32'h0, 32'h2);
    wr(2'd3, 32'h2);
    rd(2'd3);
    check("w1c_after_collision", rd0, 32'h0);
    wr(2'd3, 32'hF);

    // bit2 0->1->0 across edge builds
    in_port = 4'h7;
    tick(10);
    rd(2'd3);
    check3("bit2_rise", 32'h4, 32'h0, 32'h4);
    wr(2'd3, 32'hF);
    in_port = 4'h3;
    tick(10);
    rd(2'd3);
    check3("bit2_fall", 32'h0, 32'h4, 32'h4);
    wr(2'd3, 32'hF);

    // Async reset in the middle of a debounce count
    wr(2'd2, 32'hF);
    address = 2'd0;
    in_port = 4'hF;
    tick(4);
    check("midcount_data", rd0, 32'h3);
    #2 reset_n = 1'b0;
    #1;
    check3("async_reset_rd", 32'h0, 32'h0, 32'h0);
    check("async_reset_irq", {31'h0, irq0 | irq1 | irq2}, 32'h0);
    in_port = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick(15);
    rd(2'd3);
    check3("post_reset_edgecap", 32'h0, 32'h0, 32'h0);
    rd(2'd0);
    check3("post_reset_data", 32'h0, 32'h0, 32'h0);
    rd(2'd2);
    check("post_reset_mask", rd0, 32'h0);
    check("post_reset_irq", {31'h0, irq0 | irq1 | irq2}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
